// File: rtl/commit_trace_packer.sv
// Commit trace packer: stamps up to two retiring instructions per cycle with a
// free-running cycle count and queues them as fixed-width trace records.
// Commits that do not fit are dropped, counted, and flagged on the next record.
module commit_trace_packer #(
  parameter int DEPTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         enable_i,
  input  logic         clear_i,
  input  logic [1:0]   commit_valid_i,
  input  logic [127:0] commit_pc_i,
  input  logic [63:0]  commit_instr_i,
  input  logic [9:0]   commit_rd_i,
  input  logic [1:0]   commit_we_i,
  input  logic [127:0] commit_wdata_i,
  input  logic [1:0]   priv_lvl_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [203:0] out_rec_o,
  output logic [15:0]  drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = 204;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [RW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;
  logic [31:0]   cycle_q;
  logic [15:0]   drop_q;
  logic          lost_q;

  logic [AW:0]   occ;
  logic [AW:0]   free_cnt;
  logic          full;
  logic          req0;
  logic          req1;
  logic          acc0;
  logic          acc1;
  logic          deq;
  logic [1:0]    num_acc;
  logic [1:0]    num_drop;
  logic [16:0]   drop_sum;
  logic [15:0]   drop_next;
  logic          lost_d;
  logic [AW-1:0] idx0;
  logic [AW-1:0] idx1;
  logic [RW-1:0] rec0;
  logic [RW-1:0] rec1;

  // Admission: free space is judged on start-of-cycle occupancy, oldest port first
  always_comb begin
    occ      = wr_ptr_q - rd_ptr_q;
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    free_cnt = DEPTH_C - occ;
    req0     = enable_i & commit_valid_i[0];
    req1     = enable_i & commit_valid_i[1];
    acc0     = req0 & ~full;
    acc1     = req1 & (req0 ? (free_cnt > (AW+1)'(1)) : ~full);
    deq      = out_valid_o & out_ready_i;
    num_acc  = {1'b0, acc0} + {1'b0, acc1};
    num_drop = {1'b0, req0 & ~acc0} + {1'b0, req1 & ~acc1};
    drop_sum = {1'b0, drop_q} + {15'b0, num_drop};
    drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    // A drop always happens after any same-cycle accept, so it marks the next record
    if (num_drop != 2'd0) begin
      lost_d = 1'b1;
    end else if (num_acc != 2'd0) begin
      lost_d = 1'b0;
    end else begin
      lost_d = lost_q;
    end
    idx0 = wr_ptr_q[AW-1:0];
    idx1 = acc0 ? idx0 + AW'(1) : idx0;
    // Top three bits are padding; the packed record fields occupy bits 200:0
    rec0 = {3'b000, lost_q, cycle_q, priv_lvl_i, commit_we_i[0], commit_rd_i[4:0],
            commit_instr_i[31:0], commit_pc_i[63:0], commit_wdata_i[63:0]};
    rec1 = {3'b000, (acc0 ? 1'b0 : lost_q), cycle_q, priv_lvl_i, commit_we_i[1],
            commit_rd_i[9:5], commit_instr_i[63:32], commit_pc_i[127:64],
            commit_wdata_i[127:64]};
  end

  // Pointers, cycle stamp, drop counter and lost flag; clear wins over traffic
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      drop_q   <= '0;
      lost_q   <= 1'b0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (clear_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        drop_q   <= '0;
        lost_q   <= 1'b0;
      end else begin
        wr_ptr_q <= wr_ptr_q + (AW+1)'(num_acc);
        rd_ptr_q <= rd_ptr_q + (AW+1)'(deq);
        drop_q   <= drop_next;
        lost_q   <= lost_d;
      end
    end
  end

  // Record storage; contents are only visible while the pointers say valid
  always_ff @(posedge clk_i) begin
    if (!clear_i) begin
      if (acc0) begin
        mem_q[idx0] <= rec0;
      end
      if (acc1) begin
        mem_q[idx1] <= rec1;
      end
    end
  end

  assign out_valid_o = (wr_ptr_q != rd_ptr_q);
  assign out_rec_o   = out_valid_o ? mem_q[rd_ptr_q[AW-1:0]] : '0;
  assign drop_cnt_o  = drop_q;

endmodule

// File: doc/commit_trace_packer.md
COMMIT_TRACE_PACKER -- requirements
Module: commit_trace_packer

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; SHALL be a power of 2 and at least 4.
REQ-002 clk_i  input  1  sole clock, rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 enable_i  input  1  tracing enable; low blocks all enqueues.
REQ-005 clear_i  input  1  synchronous clear of FIFO, drop counter and lost flag.
REQ-006 commit_valid_i  input  2  per-port commit strobe; port 0 is older than port 1.
REQ-007 commit_pc_i  input  2x64  committed PC per port.
REQ-008 commit_instr_i  input  2x32  instruction word per port.
REQ-009 commit_rd_i  input  2x5  destination register per port.
REQ-010 commit_we_i  input  2  register write valid per port.
REQ-011 commit_wdata_i  input  2x64  write-back data per port.
REQ-012 priv_lvl_i  input  2  current privilege level, shared by both ports.
REQ-013 out_valid_o  output  1  record available.
REQ-014 out_ready_i  input  1  consumer accepts record.
REQ-015 out_rec_o  output  204  record {lost[1], cycle[32], priv[2], we[1], rd[5], instr[32], pc[64], wdata[64]}, MSB first.
REQ-016 drop_cnt_o  output  16  count of dropped commits, saturating.

Function
REQ-017 Free-running 32-bit cycle counter SHALL increment every cycle out of reset and wrap 0xFFFFFFFF->0; clear_i SHALL NOT reset it.
REQ-018 Each record SHALL carry the counter value of the cycle in which its commit was sampled; two same-cycle commits SHALL carry identical stamps.
REQ-019 When enable_i=1, each set commit_valid_i bit SHALL request one enqueue; port 0 is enqueued before port 1; valid only on port 1 SHALL enqueue a single record.
REQ-020 Free space SHALL be DEPTH minus occupancy at the start of the cycle; a same-cycle dequeue SHALL NOT create space for same-cycle enqueues.
REQ-021 If requests exceed free space, the SHALL accept requests in port order up to free space and drop the remainder.
REQ-022 Each dropped commit SHALL increment drop_cnt_o by 1 (by 2 if both drop); drop_cnt_o SHALL saturate at 0xFFFF.
REQ-023 Any drop SHALL set an internal lost flag; the next accepted record SHALL have lost=1, and the flag SHALL then clear.
REQ-024 A drop and an accept in the same cycle (port 0 accepted, port 1 dropped) SHALL give the port-0 record lost=0; the flag SHALL apply to the next later record.
REQ-025 out_valid_o SHALL equal (occupancy != 0); out_rec_o SHALL be the head entry.
REQ-026 A record is consumed when out_valid_o and out_ready_i are both 1; head advances next cycle.
REQ-027 While out_valid_o=1 and out_ready_i=0, out_rec_o SHALL be held stable.
REQ-028 Enqueue-to-out_valid_o latency SHALL be 1 cycle; with an empty FIFO and ready=1, throughput SHALL be one record per cycle.
REQ-029 Read and write pointers SHALL be log2(DEPTH)+1 bits with wrap bit; full = MSBs differ, lower bits equal.
REQ-030 clear_i SHALL take priority over enqueue and dequeue in the same cycle: occupancy 0, drop_cnt_o 0, lost flag 0; commits of that cycle are discarded and not counted.
REQ-031 enable_i=0 SHALL NOT affect dequeue; commits seen while disabled SHALL NOT count as drops.

Reset
REQ-032 During reset: out_valid_o=0, out_rec_o=0, drop_cnt_o=0, pointers 0, lost flag 0, cycle counter 0.
REQ-033 An assertion of rst_ni mid-stream SHALL immediately discard all buffered records; the first cycle after release SHALL have cycle counter 0.

Verification
REQ-034 Single commit, pc=0x80000000, instr=0x00000013, ready=1 -> next cycle out_valid_o=1 with that pc and instr, lost=0; the cycle after, out_valid_o=0.
REQ-035 Both ports valid in the counter=5 cycle -> two records in order port0, port1, both cycle=5.
REQ-036 DEPTH=8, ready=0, 5 cycles of dual commits -> 8 stored, drop_cnt_o=2; the next accepted record after ready=1 has lost=1.
REQ-037 FIFO at 7 entries, dual commit, simultaneous dequeue -> port 0 accepted, port 1 dropped, drop_cnt_o +1, occupancy stays 7.
REQ-038 drop_cnt_o=0xFFFF, further drops -> remains 0xFFFF; clear_i with a dual commit -> occupancy 0, drop_cnt_o 0, no record emitted.
REQ-039 rst_ni low with 4 buffered records -> out_valid_o=0 at once; after release, no stale record appears.
